// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: start/data/parity/stop deserialiser with
// a mid-frame inactivity timeout, feeding a first-word-fall-through frame FIFO.
module ps2_frame_receiver #(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned PARITY_CHECK   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 ps2_clk_posedge,
  input  logic                 ps2_data,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  output logic                 overflow_strb,
  output logic                 timeout_strb
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned EW = DATA_BITS + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  logic [BW-1:0]        r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic [TW-1:0]        r_tmo;
  logic                 r_tmo_strb;

  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr;
  logic [AW-1:0]        r_rd;
  logic [CW-1:0]        r_count;
  logic                 r_ovf_strb;

  logic                 w_push;
  logic                 w_perr;
  logic [EW-1:0]        w_entry;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_wr_ok;
  logic [EW-1:0]        w_head;

  // The stop-bit posedge pushes directly from the live shift register and line
  // value, so the entry lands in the FIFO on that same clock edge.
  assign w_push  = (r_state == S_STOP) && ps2_clk_posedge;
  assign w_perr  = (PARITY_CHECK != 0) && !(^{r_shift, r_parity});
  assign w_entry = {~ps2_data, w_perr, r_shift};

  assign w_pop   = (r_count != '0) && rx_ready;
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign w_wr_ok = w_push && (!w_full || w_pop);
  assign w_head  = r_mem[r_rd];

  // Frame deserialiser FSM with inactivity timeout while a frame is open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tmo      <= '0;
      r_tmo_strb <= 1'b0;
    end else begin
      r_tmo_strb <= 1'b0;
      if (r_state == S_IDLE) begin
        r_tmo <= '0;
        if (ps2_clk_posedge && !ps2_data && enable) begin
          r_state  <= S_DATA;
          r_bitcnt <= '0;
          r_shift  <= '0;
        end
      end else if (ps2_clk_posedge) begin
        r_tmo <= '0;
        case (r_state)
          S_DATA: begin
            r_shift <= {ps2_data, r_shift[DATA_BITS-1:1]};
            if (r_bitcnt == BW'(DATA_BITS - 1)) begin
              r_bitcnt <= '0;
              r_state  <= S_PARITY;
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
          S_PARITY: begin
            r_parity <= ps2_data;
            r_state  <= S_STOP;
          end
          default: begin
            r_shift <= '0;
            r_state <= S_IDLE;
          end
        endcase
      end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
        r_state    <= S_IDLE;
        r_tmo      <= '0;
        r_shift    <= '0;
        r_bitcnt   <= '0;
        r_tmo_strb <= 1'b1;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because reads are gated by the count.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr] <= w_entry;
    end
  end

  // FIFO pointers, occupancy and overflow strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_ovf_strb <= 1'b0;
    end else begin
      r_ovf_strb <= w_push && w_full && !w_pop;
      if (w_wr_ok) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_wr_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rx_valid      = (r_count != '0);
  assign rx_data       = rx_valid ? w_head[DATA_BITS-1:0] : '0;
  assign rx_parity_err = rx_valid & w_head[DATA_BITS];
  assign rx_frame_err  = rx_valid & w_head[DATA_BITS+1];
  assign overflow_strb = r_ovf_strb;
  assign timeout_strb  = r_tmo_strb;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Bench for ps2_frame_receiver: directed frames plus randomized traffic, checked
// every cycle against a bit-list / queue model of the receiver and its FIFO.
module tb_ps2_frame_receiver;

  localparam int unsigned DB    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          ps2_clk_posedge = 1'b0;
  logic          ps2_data = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] rx_data, rx_data_np;
  logic          rx_parity_err, rx_parity_err_np;
  logic          rx_frame_err, rx_frame_err_np;
  logic          rx_valid, rx_valid_np;
  logic          overflow_strb, overflow_strb_np;
  logic          timeout_strb, timeout_strb_np;

  ps2_frame_receiver #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .PARITY_CHECK(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ps2_clk_posedge(ps2_clk_posedge),
    .ps2_data(ps2_data), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_valid(rx_valid),
    .overflow_strb(overflow_strb), .timeout_strb(timeout_strb));

  ps2_frame_receiver #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .PARITY_CHECK(0)) u_dut_np (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ps2_clk_posedge(ps2_clk_posedge),
    .ps2_data(ps2_data), .rx_ready(rx_ready), .rx_data(rx_data_np),
    .rx_parity_err(rx_parity_err_np), .rx_frame_err(rx_frame_err_np), .rx_valid(rx_valid_np),
    .overflow_strb(overflow_strb_np), .timeout_strb(timeout_strb_np));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic          fe;
    logic          pe;
    logic [DB-1:0] d;
  } ent_t;

  ent_t mq[$];
  bit   m_bits[$];
  int   m_idle = 0;
  bit   exp_ovf = 1'b0;
  bit   exp_tmo = 1'b0;

  // Frame = list of sampled line bits; complete after start+data+parity+stop.
  initial forever begin
    bit   pop_now, push_now;
    ent_t e;
    int   ones;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete(); m_bits.delete(); m_idle = 0; exp_ovf = 1'b0; exp_tmo = 1'b0;
    end else begin
      exp_ovf  = 1'b0;
      exp_tmo  = 1'b0;
      pop_now  = rx_ready && (mq.size() > 0);
      push_now = 1'b0;
      e        = '0;
      if (m_bits.size() == 0) begin
        if (ps2_clk_posedge && !ps2_data && enable) begin
          m_bits.push_back(1'b0);
          m_idle = 0;
        end
      end else if (ps2_clk_posedge) begin
        m_bits.push_back(ps2_data);
        m_idle = 0;
        if (m_bits.size() == DB + 3) begin
          ones = 0;
          for (int i = 0; i < DB; i++) begin
            e.d[i] = m_bits[1 + i];
            ones += int'(m_bits[1 + i]);
          end
          ones += int'(m_bits[DB + 1]);
          e.pe = (ones % 2 == 0);
          e.fe = !m_bits[DB + 2];
          push_now = 1'b1;
          m_bits.delete();
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          exp_tmo = 1'b1;
          m_bits.delete();
          m_idle = 0;
        end
      end
      if (pop_now) void'(mq.pop_front());
      if (push_now) begin
        if (mq.size() < DEPTH) mq.push_back(e);
        else exp_ovf = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  initial forever begin
    ent_t h;
    @(posedge clk);
    #1;
    h = (mq.size() > 0) ? mq[0] : '0;
    chk("rx_valid", rx_valid, mq.size() > 0);
    chk("rx_data", rx_data, h.d);
    chk("rx_parity_err", rx_parity_err, h.pe);
    chk("rx_frame_err", rx_frame_err, h.fe);
    chk("overflow_strb", overflow_strb, exp_ovf);
    chk("timeout_strb", timeout_strb, exp_tmo);
    chk("np_rx_valid", rx_valid_np, mq.size() > 0);
    chk("np_rx_data", rx_data_np, h.d);
    chk("np_rx_parity_err", rx_parity_err_np, 1'b0);
    chk("np_rx_frame_err", rx_frame_err_np, h.fe);
  end

  int ovf_cnt = 0;
  int tmo_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (overflow_strb) ovf_cnt++;
    if (timeout_strb) tmo_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  bit rand_ready = 1'b0;

  task automatic cycle(input bit pos, input bit d);
    @(posedge clk);
    #3;
    ps2_clk_posedge = pos;
    if (pos) ps2_data = d;
    if (rand_ready) rx_ready = ($urandom_range(0, 2) == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0);
  endtask

  task automatic send_bit(input bit b, input int gap);
    idle(gap);
    cycle(1'b1, b);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input bit par, input bit stop);
    send_bit(1'b0, 1);
    for (int i = 0; i < DB; i++) send_bit(d[i], 1);
    send_bit(par, 1);
    send_bit(stop, 1);
    idle(2);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    @(posedge clk);
    #3;
    rx_ready = 1'b0;
  endtask

  task automatic chk_head(input string name, input logic [DB-1:0] d, input bit pe, input bit fe);
    chk({name, "_valid"}, rx_valid, 1'b1);
    chk({name, "_data"}, rx_data, d);
    chk({name, "_perr"}, rx_parity_err, pe);
    chk({name, "_ferr"}, rx_frame_err, fe);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, rx_valid, 1'b0);
    chk({name, "_data"}, rx_data, '0);
    chk({name, "_perr"}, rx_parity_err, 1'b0);
    chk({name, "_ferr"}, rx_frame_err, 1'b0);
    chk({name, "_ovf"}, overflow_strb, 1'b0);
    chk({name, "_tmo"}, timeout_strb, 1'b0);
  endtask

  int            snap;
  logic [DB-1:0] rd;
  bit            rp, rs;
  int            g;

  initial begin
    // reset
    idle(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    enable = 1'b1;
    idle(2);

    // basic 0x1C frame with good parity and stop
    send_frame(8'h1C, 1'b0, 1'b1);
    chk_head("f1C", 8'h1C, 1'b0, 1'b0);
    chk("model_head_1C", mq[0].d, 8'h1C);
    chk("np_f1C_perr", rx_parity_err_np, 1'b0);
    pop_one();
    chk("f1C_popped_valid", rx_valid, 1'b0);

    // bad parity; the unchecked instance must ignore it
    send_frame(8'h1C, 1'b1, 1'b1);
    chk_head("badpar", 8'h1C, 1'b1, 1'b0);
    chk("model_badpar_pe", mq[0].pe, 1'b1);
    chk("np_badpar_perr", rx_parity_err_np, 1'b0);
    pop_one();

    // stop bit 0 still produces an entry
    send_frame(8'h1C, 1'b0, 1'b0);
    chk_head("badstop", 8'h1C, 1'b0, 1'b1);
    pop_one();
    chk("badstop_popped_valid", rx_valid, 1'b0);

    // overflow on the fifth frame into a depth-4 FIFO
    snap = ovf_cnt;
    for (int k = 1; k <= 5; k++) begin
      rd = 8'(k);
      send_frame(rd, ~^rd, 1'b1);
    end
    chk("ovf_pulses", ovf_cnt - snap, 1);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_pop_valid", rx_valid, 1'b1);
      chk("ovf_pop_data", rx_data, k);
      pop_one();
    end
    chk("ovf_drained_valid", rx_valid, 1'b0);

    // timeout mid-frame, then a clean 0x5A frame
    snap = tmo_cnt;
    send_bit(1'b0, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
    idle(TMO + 5);
    chk("tmo_pulses", tmo_cnt - snap, 1);
    chk("tmo_valid", rx_valid, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b1);
    chk_head("after_tmo", 8'h5A, 1'b0, 1'b0);
    pop_one();

    // reset mid-frame with an entry already buffered
    send_frame(8'h33, 1'b1, 1'b1);
    send_bit(1'b0, 1);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk_head("after_reset", 8'h1C, 1'b0, 1'b0);
    pop_one();

    // randomized traffic: enable toggling, idle-line noise, parity/stop errors,
    // occasional over-long gaps, and a randomly stalling consumer
    rand_ready = 1'b1;
    for (int f = 0; f < 300; f++) begin
      rd = 8'($urandom);
      rp = ($urandom_range(0, 4) == 0) ? ^rd : ~^rd;
      rs = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) send_bit(1'b1, $urandom_range(0, 3));
      enable = ($urandom_range(0, 9) != 0);
      send_bit(1'b0, $urandom_range(0, 4));
      enable = ($urandom_range(0, 1) == 0);
      for (int i = 0; i < DB + 2; i++) begin
        g = ($urandom_range(0, 79) == 0) ? int'(TMO) + 2 : int'($urandom_range(0, 5));
        if (i < DB) send_bit(rd[i], g);
        else if (i == DB) send_bit(rp, g);
        else send_bit(rs, g);
      end
      idle($urandom_range(0, 4));
    end
    rand_ready = 1'b0;
    rx_ready = 1'b1;
    idle(TMO + 10);
    chk("final_drained", rx_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_frame_receiver.md
PS2_FRAME_RECEIVER -- requirements
Module: ps2_frame_receiver

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: payload bits per frame, range 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: received-frame buffer entries, power of two, 2..16.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 10000: idle clk cycles mid-frame before abort, at least 2.
REQ-004 SHALL have parameter PARITY_CHECK, default 1: 1 = odd-parity check enabled, 0 = parity bit sampled and ignored.
REQ-005 SHALL have port clk, input, 1: system clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port enable, input, 1: permits start-bit detection.
REQ-008 SHALL have port ps2_clk_posedge, input, 1: single-cycle pulse on each PS/2 clock rising edge, pre-synchronised.
REQ-009 SHALL have port ps2_data, input, 1: synchronised PS/2 data line.
REQ-010 SHALL have port rx_ready, input, 1: consumer pops the head entry.
REQ-011 SHALL have port rx_data, output, DATA_BITS: head-of-FIFO payload.
REQ-012 SHALL have port rx_parity_err, output, 1: head entry failed parity.
REQ-013 SHALL have port rx_frame_err, output, 1: head entry had a stop bit of 0.
REQ-014 SHALL have port rx_valid, output, 1: FIFO not empty.
REQ-015 SHALL have port overflow_strb, output, 1: one-cycle pulse, frame dropped because the FIFO was full.
REQ-016 SHALL have port timeout_strb, output, 1: one-cycle pulse, frame aborted on timeout.

Function
REQ-017 SHALL sample ps2_data only in cycles where ps2_clk_posedge=1.
REQ-018 SHALL implement states IDLE, DATA, PARITY and STOP.
REQ-019 IDLE->DATA SHALL occur on ps2_clk_posedge with ps2_data=0 and enable=1; otherwise the FSM stays in IDLE.
REQ-020 In DATA, the FSM SHALL shift bits LSB first and advance to PARITY on the posedge that captures bit DATA_BITS-1.
REQ-021 PARITY->STOP SHALL occur on the next posedge, capturing the parity bit.
REQ-022 STOP->IDLE SHALL occur on the next posedge, capturing the stop bit and pushing one entry {frame_err, parity_err, data}.
REQ-023 parity_err SHALL be 1 when PARITY_CHECK=1 and the XOR of the data bits and the parity bit is 0; otherwise parity_err SHALL be 0.
REQ-024 frame_err SHALL be 1 when the stop bit is 0, and the entry SHALL still be pushed.
REQ-025 enable=0 SHALL NOT abort a frame in progress; it blocks only new start-bit detection.
REQ-026 A timeout counter SHALL clear on each posedge and in IDLE, and increment each cycle in DATA, PARITY or STOP.
REQ-027 On reaching TIMEOUT_CYCLES-1, the FSM SHALL go to IDLE, pulse timeout_strb for one cycle, and push nothing; the shift register and bit counter SHALL clear.
REQ-028 The FIFO SHALL be first-word-fall-through: rx_valid=1 whenever count>0, and rx_data/rx_parity_err/rx_frame_err SHALL show the head entry.
REQ-029 A pop SHALL occur when rx_valid and rx_ready are both 1, with the next entry visible in the following cycle.
REQ-030 Push while full with no pop SHALL drop the new frame, pulse overflow_strb for one cycle, and leave stored entries unchanged.
REQ-031 Simultaneous push and pop SHALL keep the count unchanged, including when full, with no overflow.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-033 Outputs SHALL hold 0 when rx_valid=0.
REQ-034 Frame-to-strobe latency SHALL be one clk from the stop-bit posedge to rx_valid rising, when the FIFO was empty.

Reset
REQ-035 Asserting rst_n=0 SHALL immediately force state IDLE, clear the FIFO pointers, count, bit counter, shift register and timeout counter, and drive all outputs to 0.
REQ-036 Reset mid-frame SHALL discard the partial frame; the first frame after release SHALL be received correctly.

Verification
REQ-037 Bench SHALL cover: frame 0,0,0,1,1,1,0,0,0, parity 0, stop 1 with rx_ready=0 -> rx_data=0x1C, rx_valid=1, both errors 0.
REQ-038 Bench SHALL cover: same frame with parity bit 1 -> rx_parity_err=1; with PARITY_CHECK=0 -> rx_parity_err=0.
REQ-039 Bench SHALL cover: 0x1C frame with stop bit 0 -> rx_frame_err=1, entry present.
REQ-040 Bench SHALL cover: FIFO_DEPTH=4, five frames 0x01..0x05 with rx_ready=0 -> overflow_strb pulses once on the fifth; pops return 0x01..0x04 in order, then rx_valid=0.
REQ-041 Bench SHALL cover: start plus 4 data bits then no posedge for TIMEOUT_CYCLES -> timeout_strb pulses once, rx_valid stays 0, and the next full 0x5A frame is received correctly.
REQ-042 Bench SHALL cover: rst_n pulsed low after 3 data bits -> all outputs 0, and the following 0x1C frame is received with no errors.
